barrel_shifter_pipe: RTL and testbench

//   Parametrised, pipelined log-depth barrel shifter for the datapath.

---
 rtl/barrel_shifter_pipe.sv | 83 ++++++++
 tb/tb_barrel_shifter_pipe.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/barrel_shifter_pipe.sv
// Pipelined log-depth barrel shifter: one register stage per shift level.
// Stage k applies the 2^k shift, so the last stage holds the full shifted result.
module barrel_shifter_pipe #(
  parameter int WIDTH = 16,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SHW-1:0]   in_shamt,
  input  logic [2:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             busy
);

  // Handshake: a transfer happens on a rising edge where valid && ready.
  // in_ready drops only while the last stage holds a result the consumer refuses.

  localparam logic [2:0] OP_SRL = 3'b000;
  localparam logic [2:0] OP_SLL = 3'b001;
  localparam logic [2:0] OP_SRA = 3'b010;
  localparam logic [2:0] OP_ROR = 3'b011;
  localparam logic [2:0] OP_ROL = 3'b100;

  logic [SHW-1:0]   st_valid;
  logic [WIDTH-1:0] st_data  [SHW];
  logic [2:0]       st_op    [SHW];
  logic [SHW-1:0]   st_shamt [SHW];
  logic             stall;

  // SRA keeps the MSB at every level, so the current MSB is the original sign.
  function automatic logic [WIDTH-1:0] shift_level(input logic [WIDTH-1:0] d,
                                                   input logic [2:0]       op,
                                                   input int               n);
    logic [WIDTH-1:0]        r;
    logic signed [WIDTH-1:0] sd;
    sd = d;
    case (op)
      OP_SRL:  r = d >> n;
      OP_SLL:  r = d << n;
      OP_SRA:  r = sd >>> n;
      OP_ROR:  r = (d >> n) | (d << (WIDTH - n));
      OP_ROL:  r = (d << n) | (d >> (WIDTH - n));
      default: r = d;
    endcase
    return r;
  endfunction

  assign stall     = st_valid[SHW-1] && !out_ready;
  assign in_ready  = !stall;
  assign out_valid = st_valid[SHW-1];
  assign out_data  = st_data[SHW-1];
  assign busy      = |st_valid;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st_valid <= '0;
      for (int k = 0; k < SHW; k++) begin
        st_data[k]  <= '0;
        st_op[k]    <= '0;
        st_shamt[k] <= '0;
      end
    end else if (!stall) begin
      // Bubbles still move their (don't-care) payload along with valid=0.
      st_valid[0] <= in_valid && in_ready;
      st_data[0]  <= in_shamt[0] ? shift_level(in_data, in_op, 1) : in_data;
      st_op[0]    <= in_op;
      st_shamt[0] <= in_shamt;
      for (int k = 1; k < SHW; k++) begin
        st_valid[k] <= st_valid[k-1];
        st_data[k]  <= st_shamt[k-1][k] ? shift_level(st_data[k-1], st_op[k-1], 1 << k)
                                        : st_data[k-1];
        st_op[k]    <= st_op[k-1];
        st_shamt[k] <= st_shamt[k-1];
      end
    end
  end

endmodule

// File: tb/tb_barrel_shifter_pipe.sv
// Bench for barrel_shifter_pipe (WIDTH=16): directed vector table, stream,
// backpressure and reset sequences, plus randomized traffic against a reference model.
module tb_barrel_shifter_pipe;
  localparam int W  = 16;
  localparam int SW = 4;
  localparam int NV = 14;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  in_data = '0;
  logic [SW-1:0] in_shamt = '0;
  logic [2:0]    in_op = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [W-1:0]  out_data;
  logic          busy;

  int n_cmp = 0;
  int n_err = 0;
  logic [W-1:0] exp_q[$];
  logic         prev_stall = 1'b0;
  logic [W-1:0] prev_data = '0;
  logic         rand_done = 1'b0;

  typedef struct {
    logic [2:0]    op;
    logic [W-1:0]  data;
    logic [SW-1:0] shamt;
    logic [W-1:0]  exp;
  } vec_t;
  vec_t vecs[NV];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  barrel_shifter_pipe #(.WIDTH(W)) dut (
    .clk      (clk),
    .reset    (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_shamt (in_shamt),
    .in_op    (in_op),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .busy     (busy)
  );

  // Reference: full-amount shift computed in 32-bit arithmetic.
  function automatic logic [W-1:0] ref_shift(input logic [2:0] op, input logic [W-1:0] d,
                                             input int s);
    logic [31:0] w;
    logic [31:0] r;
    w = {16'h0000, d};
    case (op)
      3'd0:    r = w >> s;
      3'd1:    r = w << s;
      3'd2:    r = (w >> s) | (d[W-1] ? (32'hFFFF_0000 >> s) : 32'h0);
      3'd3:    r = (w >> s) | (w << (W - s));
      3'd4:    r = (w << s) | (w >> (W - s));
      default: r = w;
    endcase
    return r[W-1:0];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [2:0] op, input logic [W-1:0] d, input logic [SW-1:0] s);
    logic acc;
    int   t;
    in_valid = 1'b1;
    in_op    = op;
    in_data  = d;
    in_shamt = s;
    t = 0;
    do begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      t++;
    end while (!acc && t < 200);
    if (!acc) chk("send_accept_timeout", 32'(acc), 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output logic [W-1:0] d, output int lat);
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("wait_out_valid", 32'(out_valid), 32'd1);
    d = out_data;
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 100) begin
      @(posedge clk);
      #1;
      t++;
    end
    chk("drain_empty", 32'(exp_q.size()), 32'd0);
    chk("drain_busy", 32'(busy), 32'd0);
  endtask

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      prev_stall = 1'b0;
      chk("reset_out_valid", 32'(out_valid), 32'd0);
      chk("reset_busy", 32'(busy), 32'd0);
      chk("reset_out_data", 32'(out_data), 32'd0);
    end else begin
      chk("in_ready_rule", 32'(in_ready), 32'(!(out_valid && !out_ready)));
      if (prev_stall) begin
        chk("stall_hold_valid", 32'(out_valid), 32'd1);
        chk("stall_hold_data", 32'(out_data), 32'(prev_data));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_output", 32'(out_data), 32'hDEAD_0000);
        end else begin
          chk("sb_out_data", 32'(out_data), 32'(exp_q.pop_front()));
        end
      end
      if (in_valid && in_ready) exp_q.push_back(ref_shift(in_op, in_data, int'(in_shamt)));
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
    end
  end

  // ---------------- test sequence ----------------
  initial begin
    logic [W-1:0] got;
    int           lat;

    vecs[0]  = '{3'b000, 16'h8001, 4'd1,  16'h4000};
    vecs[1]  = '{3'b010, 16'h8000, 4'd4,  16'hF800};
    vecs[2]  = '{3'b010, 16'h7000, 4'd4,  16'h0700};
    vecs[3]  = '{3'b001, 16'h00FF, 4'd8,  16'hFF00};
    vecs[4]  = '{3'b100, 16'h8001, 4'd1,  16'h0003};
    vecs[5]  = '{3'b011, 16'h0001, 4'd15, 16'h0002};
    vecs[6]  = '{3'b111, 16'h1234, 4'd5,  16'h1234};
    vecs[7]  = '{3'b000, 16'hFFFF, 4'd15, 16'h0001};
    vecs[8]  = '{3'b010, 16'h8000, 4'd15, 16'hFFFF};
    vecs[9]  = '{3'b010, 16'h8421, 4'd0,  16'h8421};
    vecs[10] = '{3'b011, 16'hA5C3, 4'd0,  16'hA5C3};
    vecs[11] = '{3'b101, 16'hBEEF, 4'd3,  16'hBEEF};
    vecs[12] = '{3'b100, 16'h1234, 4'd4,  16'h2341};
    vecs[13] = '{3'b001, 16'h8001, 4'd15, 16'h8000};

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("post_reset_in_ready", 32'(in_ready), 32'd1);
    chk("post_reset_out_valid", 32'(out_valid), 32'd0);
    chk("post_reset_busy", 32'(busy), 32'd0);
    chk("post_reset_out_data", 32'(out_data), 32'd0);
    @(posedge clk);
    #1;

    // Directed vector table, each from idle: value and 4-cycle latency.
    for (int i = 0; i < NV; i++) begin
      send(vecs[i].op, vecs[i].data, vecs[i].shamt);
      wait_out(got, lat);
      chk($sformatf("vec%0d_data", i), 32'(got), 32'(vecs[i].exp));
      chk($sformatf("vec%0d_latency", i), 32'(lat), 32'd4);
      idle(1);
    end
    idle(2);

    // Back-to-back SLL stream: 8 results on 8 consecutive cycles.
    fork
      begin
        for (int i = 0; i < 8; i++) send(3'b001, 16'h0001, i[SW-1:0]);
      end
      begin
        int t;
        t = 0;
        while (!out_valid && t < 40) begin
          @(posedge clk);
          #1;
          t++;
        end
        for (int j = 0; j < 8; j++) begin
          chk("stream_valid", 32'(out_valid), 32'd1);
          chk("stream_data", 32'(out_data), 32'(1 << j));
          @(posedge clk);
          #1;
        end
      end
    join
    drain();

    // Backpressure: out_ready low for 6 cycles mid-stream.
    fork
      begin
        for (int i = 0; i < 10; i++)
          send(3'($urandom_range(0, 7)), 16'($urandom), 4'($urandom_range(0, 15)));
      end
      begin
        repeat (6) begin
          @(posedge clk);
          #1;
        end
        out_ready = 1'b0;
        #1;
        chk("stall_in_ready", 32'(in_ready), 32'd0);
        chk("stall_out_valid", 32'(out_valid), 32'd1);
        repeat (6) @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();

    // Reset with 3 ops in flight: results discarded, next op from idle.
    send(3'b001, 16'h00F0, 4'd2);
    send(3'b011, 16'h1357, 4'd5);
    send(3'b010, 16'hF00D, 4'd7);
    chk("inflight_busy", 32'(busy), 32'd1);
    chk("inflight_out_valid", 32'(out_valid), 32'd0);
    rst = 1'b1;
    #1;
    chk("async_reset_out_valid", 32'(out_valid), 32'd0);
    chk("async_reset_busy", 32'(busy), 32'd0);
    chk("async_reset_out_data", 32'(out_data), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    idle(6);
    chk("flushed_no_output", 32'(busy), 32'd0);
    send(3'b000, 16'hF000, 4'd12);
    wait_out(got, lat);
    chk("after_reset_data", 32'(got), 32'h0000_000F);
    chk("after_reset_latency", 32'(lat), 32'd4);
    drain();

    // Randomized ops, amounts, gaps and backpressure.
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 2)));
          send(3'($urandom_range(0, 7)), 16'($urandom), 4'($urandom_range(0, 15)));
        end
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk);
          #1;
          out_ready = ($urandom_range(0, 2) != 0);
        end
        out_ready = 1'b1;
      end
    join
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
